// File: rtl/lfsr_rng_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : lfsr_rng_pkg                                                  |
// | Purpose  : Shared FSM encoding and Fibonacci LFSR step function.         |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package lfsr_rng_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } rng_fsm_t;

    // Operates on a zero-extended 32-bit view so one function serves every width.
    function automatic logic [31:0] lfsr_next(
        input logic [31:0] state,
        input logic [31:0] taps,
        input int unsigned width
    );
        logic fb;
        fb = ^(state & taps);
        return (state >> 1) | ({31'b0, fb} << (width - 1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr_rng_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : lfsr_core                                                     |
// | Purpose  : LFSR state register with load and shift controls.             |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module lfsr_core
    import lfsr_rng_pkg::*;
#(
    parameter int unsigned        WIDTH        = 8,
    parameter logic [WIDTH-1:0]   TAPS         = 8'h71,
    parameter logic [WIDTH-1:0]   DEFAULT_SEED = 8'h01
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             shift_en,
    input  logic             load_en,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] state,
    output logic [WIDTH-1:0] state_next
);

    localparam logic [31:0] c_TAPS_EXT = 32'(TAPS);

    logic [WIDTH-1:0] r_state;

    assign state_next = WIDTH'(lfsr_next(32'(r_state), c_TAPS_EXT, WIDTH));
    assign state      = r_state;

    // Load outranks shift so a seed always lands exactly as given.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= DEFAULT_SEED;
        end else if (load_en) begin
            r_state <= load_val;
        end else if (shift_en) begin
            r_state <= state_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/lfsr_rng.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : lfsr_rng                                                      |
// | Purpose  : Decimating Fibonacci LFSR word generator with valid/ready.    |
// |            Define LFSR_RNG_PERIOD_MON_EN to add the period monitor.      |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module lfsr_rng
    import lfsr_rng_pkg::*;
#(
    parameter int unsigned        WIDTH        = 8,
    parameter logic [WIDTH-1:0]   TAPS         = 8'h71,
    parameter logic [WIDTH-1:0]   DEFAULT_SEED = 8'h01,
    parameter int unsigned        DECIM        = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             lockup
`ifdef LFSR_RNG_PERIOD_MON_EN
    ,
    output logic             period_wrap,
    output logic [WIDTH-1:0] period_len
`endif
);

    localparam logic [7:0] c_STEP_LAST = 8'(DECIM - 1);

    rng_fsm_t         r_fsm;
    logic [7:0]       r_step_cnt;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic             r_lockup;

    logic             w_seed_zero;
    logic [WIDTH-1:0] w_load_val;
    logic             w_shift;
    logic [WIDTH-1:0] w_state;
    logic [WIDTH-1:0] w_state_next;

    // An all-zero state would lock the LFSR forever, so it is never loaded.
    assign w_seed_zero = (seed == '0);
    assign w_load_val  = w_seed_zero ? DEFAULT_SEED : seed;
    assign w_shift     = (r_fsm == RUN) && enable && !load;

    lfsr_core #(
        .WIDTH        (WIDTH),
        .TAPS         (TAPS),
        .DEFAULT_SEED (DEFAULT_SEED)
    ) u_core (
        .clock      (clock),
        .reset      (reset),
        .shift_en   (w_shift),
        .load_en    (load),
        .load_val   (w_load_val),
        .state      (w_state),
        .state_next (w_state_next)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_fsm       <= IDLE;
            r_step_cnt  <= 8'd0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_lockup    <= 1'b0;
        end else begin
            r_lockup <= load && w_seed_zero;
            if (load) begin
                // A pending word is discarded, even if out_ready is high now.
                r_fsm       <= IDLE;
                r_step_cnt  <= 8'd0;
                r_out_valid <= 1'b0;
            end else begin
                case (r_fsm)
                    IDLE: begin
                        if (enable) begin
                            r_fsm <= RUN;
                        end
                    end
                    RUN: begin
                        if (!enable) begin
                            r_fsm <= IDLE;
                        end else if (r_step_cnt == c_STEP_LAST) begin
                            r_out_data  <= w_state_next;
                            r_out_valid <= 1'b1;
                            r_step_cnt  <= 8'd0;
                            r_fsm       <= HOLD;
                        end else begin
                            r_step_cnt <= r_step_cnt + 8'd1;
                        end
                    end
                    HOLD: begin
                        if (r_out_valid && out_ready) begin
                            r_out_valid <= 1'b0;
                            r_fsm       <= enable ? RUN : IDLE;
                        end
                    end
                    default: begin
                        r_fsm <= IDLE;
                    end
                endcase
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign lockup    = r_lockup;

`ifdef LFSR_RNG_PERIOD_MON_EN
    logic [WIDTH-1:0] r_ref_state;
    logic [WIDTH-1:0] r_period_cnt;
    logic             r_period_wrap;
    logic [WIDTH-1:0] r_period_len;

    // Period is measured against whatever value the LFSR last started from.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ref_state   <= DEFAULT_SEED;
            r_period_cnt  <= '0;
            r_period_wrap <= 1'b0;
            r_period_len  <= '0;
        end else begin
            r_period_wrap <= 1'b0;
            if (load) begin
                r_ref_state  <= w_load_val;
                r_period_cnt <= '0;
                r_period_len <= '0;
            end else if (w_shift) begin
                if (w_state_next == r_ref_state) begin
                    r_period_wrap <= 1'b1;
                    r_period_len  <= r_period_cnt + 1'b1;
                    r_period_cnt  <= '0;
                end else begin
                    r_period_cnt <= r_period_cnt + 1'b1;
                end
            end
        end
    end

    assign period_wrap = r_period_wrap;
    assign period_len  = r_period_len;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lfsr_rng.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_lfsr_rng                                                   |
// | Purpose  : Directed self-checking bench for lfsr_rng.                    |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_lfsr_rng;
    import lfsr_rng_pkg::*;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic       a_enable, a_load, a_ready, a_valid, a_lockup;
    logic [7:0] a_seed, a_data;
    logic       b_enable, b_load, b_ready, b_valid, b_lockup;
    logic [7:0] b_seed, b_data;
    logic       c_enable, c_load, c_ready, c_valid, c_lockup;
    logic [3:0] c_seed, c_data;
`ifdef LFSR_RNG_PERIOD_MON_EN
    logic       a_wrap, b_wrap, c_wrap;
    logic [7:0] a_len, b_len;
    logic [3:0] c_len;
`endif

    int n_checks = 0;
    int n_errors = 0;

    lfsr_rng #(.WIDTH(8), .TAPS(8'h71), .DEFAULT_SEED(8'h01), .DECIM(1)) u_a (
        .clock(clock), .reset(reset), .enable(a_enable), .load(a_load), .seed(a_seed),
        .out_ready(a_ready), .out_valid(a_valid), .out_data(a_data), .lockup(a_lockup)
`ifdef LFSR_RNG_PERIOD_MON_EN
        , .period_wrap(a_wrap), .period_len(a_len)
`endif
    );

    lfsr_rng #(.WIDTH(8), .TAPS(8'h71), .DEFAULT_SEED(8'h01), .DECIM(4)) u_b (
        .clock(clock), .reset(reset), .enable(b_enable), .load(b_load), .seed(b_seed),
        .out_ready(b_ready), .out_valid(b_valid), .out_data(b_data), .lockup(b_lockup)
`ifdef LFSR_RNG_PERIOD_MON_EN
        , .period_wrap(b_wrap), .period_len(b_len)
`endif
    );

    lfsr_rng #(.WIDTH(4), .TAPS(4'h3), .DEFAULT_SEED(4'h1), .DECIM(1)) u_c (
        .clock(clock), .reset(reset), .enable(c_enable), .load(c_load), .seed(c_seed),
        .out_ready(c_ready), .out_valid(c_valid), .out_data(c_data), .lockup(c_lockup)
`ifdef LFSR_RNG_PERIOD_MON_EN
        , .period_wrap(c_wrap), .period_len(c_len)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    logic [3:0] exp_words [16] = '{4'h8, 4'h4, 4'h2, 4'h9, 4'hC, 4'h6, 4'hB, 4'h5,
                                   4'hA, 4'hD, 4'hE, 4'hF, 4'h7, 4'h3, 4'h1, 4'h8};
    logic [3:0] got_words [16];

    initial begin
        int lat;
        int idx;
        int cyc;
        int wraps;
        logic zero_seen;
        logic hold_ok;

        reset = 1'b1;
        {a_enable, a_load, a_ready, a_seed} = '0;
        {b_enable, b_load, b_ready, b_seed} = '0;
        {c_enable, c_load, c_ready, c_seed} = '0;
        for (int i = 0; i < 16; i++) got_words[i] = 4'h0;
        repeat (2) tick();
        check_eq("rst_valid", 32'(a_valid), 32'h0);
        check_eq("rst_data", 32'(a_data), 32'h0);
        check_eq("rst_lockup", 32'(a_lockup), 32'h0);
        check_eq("rst_state", 32'(u_a.w_state), 32'h01);
        reset = 1'b0;
        tick();

        // 8-bit, DECIM=1: 01 -> 80 -> 40
        a_load = 1'b1; a_seed = 8'h01;
        tick();
        a_load = 1'b0; a_enable = 1'b1;
        check_eq("a_loaded", 32'(u_a.w_state), 32'h01);
        tick();
        check_eq("a_run_novalid", 32'(a_valid), 32'h0);
        tick();
        check_eq("a_valid1", 32'(a_valid), 32'h1);
        check_eq("a_word1", 32'(a_data), 32'h80);
        check_eq("a_state1", 32'(u_a.w_state), 32'h80);
        a_ready = 1'b1;
        tick();
        check_eq("a_consumed", 32'(a_valid), 32'h0);
        a_ready = 1'b0;
        tick();
        check_eq("a_state2", 32'(u_a.w_state), 32'h40);
        check_eq("a_word2", 32'(a_data), 32'h40);
        a_enable = 1'b0;

        // 8-bit, DECIM=4: words D0 then 8D, held while not ready
        b_load = 1'b1; b_seed = 8'h01;
        tick();
        b_load = 1'b0; b_enable = 1'b1;
        tick();
        lat = 0;
        while (!b_valid && lat < 20) begin
            tick();
            lat++;
        end
        check_eq("b_latency", 32'(lat), 32'd4);
        check_eq("b_word1", 32'(b_data), 32'hD0);
        hold_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!(b_valid && b_data == 8'hD0 && u_b.w_state == 8'hD0)) hold_ok = 1'b0;
        end
        check_eq("b_hold_stable", 32'(hold_ok), 32'h1);
        b_ready = 1'b1;
        tick();
        b_ready = 1'b0;
        check_eq("b_one_transfer", 32'(b_valid), 32'h0);
        lat = 0;
        while (!b_valid && lat < 20) begin
            tick();
            lat++;
        end
        check_eq("b_latency2", 32'(lat), 32'd4);
        check_eq("b_word2", 32'(b_data), 32'h8D);
        b_load = 1'b1; b_seed = 8'h5A; b_ready = 1'b1;
        tick();
        b_load = 1'b0; b_ready = 1'b0; b_enable = 1'b0;
        check_eq("b_load_drop", 32'(b_valid), 32'h0);
        check_eq("b_load_state", 32'(u_b.w_state), 32'h5A);
        check_eq("b_load_fsm", 32'(u_b.r_fsm), 32'(IDLE));
        tick();
        check_eq("b_idle_noshift", 32'(u_b.w_state), 32'h5A);

        // 4-bit: zero seed protection
        c_load = 1'b1; c_seed = 4'h0;
        tick();
        c_load = 1'b0;
        check_eq("c_lockup_on", 32'(c_lockup), 32'h1);
        check_eq("c_lockup_state", 32'(u_c.w_state), 32'h1);
        tick();
        check_eq("c_lockup_off", 32'(c_lockup), 32'h0);

        // 4-bit full sequence with period monitor
        c_load = 1'b1; c_seed = 4'h1;
        tick();
        c_load = 1'b0; c_enable = 1'b1; c_ready = 1'b1;
        tick();
        idx = 0; cyc = 0; wraps = 0; zero_seen = 1'b0;
        while (idx < 16 && cyc < 100) begin
            tick();
            cyc++;
            if (u_c.w_state == 4'h0) zero_seen = 1'b1;
            if (c_valid) begin
                got_words[idx] = c_data;
                idx++;
            end
`ifdef LFSR_RNG_PERIOD_MON_EN
            if (c_wrap) begin
                wraps++;
                check_eq("c_period_len", 32'(c_len), 32'd15);
            end
`endif
        end
        check_eq("c_word_count", 32'(idx), 32'd16);
        for (int i = 0; i < 16; i++) begin
            check_eq($sformatf("c_word%0d", i), 32'(got_words[i]), 32'(exp_words[i]));
        end
        check_eq("c_no_zero", 32'(zero_seen), 32'h0);
`ifdef LFSR_RNG_PERIOD_MON_EN
        check_eq("c_wrap_count", 32'(wraps), 32'd1);
`endif

        // asynchronous reset between clock edges
        tick();
        tick();
        #2;
        reset = 1'b1;
        #1;
        check_eq("ar_valid", 32'(c_valid), 32'h0);
        check_eq("ar_state", 32'(u_c.w_state), 32'h1);
        check_eq("ar_step", 32'(u_c.r_step_cnt), 32'h0);
        check_eq("ar_fsm", 32'(u_c.r_fsm), 32'(IDLE));
        check_eq("ar_a_data", 32'(a_data), 32'h0);
        check_eq("ar_b_state", 32'(u_b.w_state), 32'h01);
`ifdef LFSR_RNG_PERIOD_MON_EN
        check_eq("ar_period_len", 32'(c_len), 32'h0);
        check_eq("ar_period_wrap", 32'(c_wrap), 32'h0);
`endif
        tick();
        reset = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
